instr_fetch_unit: RTL and testbench

- Fetch stage feeding the control unit and register file of the RISC-V core.
- Holds the fetch PC and issues word requests to instruction memory with a request/ready/valid handshake.
- Registers the returned instruction and presents it with Op/funct3/funct7 slices to decode, honouring downstream stall and branch redirect.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_pc_next_logic.sv | 24 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, reset/NOP defaults and
// instruction field widths also used by the control unit decoders.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    localparam int OP_W     = 7;
    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_W = 7;

endpackage

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// Next fetch address select: redirect (word-aligned target), sequential +4,
// or hold. Also flags a redirect target that is not word aligned.
module pc_next_logic (
    input  logic [31:0] fetch_pc,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        advance,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = fetch_pc;
        if (pc_src) begin
            next_pc = {pc_target[31:2], 2'b00};
        end else if (advance) begin
            // Plain 32-bit add: 32'hFFFF_FFFC wraps to zero.
            next_pc = fetch_pc + 32'd4;
        end
    end

    assign misaligned = pc_src && (pc_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word request to instruction memory, holds the
// returned instruction for decode, honours stall and branch redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Stall,
    input  logic                PCSrc,
    input  logic [31:0]         PCTarget,
    output logic                ImemReq,
    output logic [31:0]         ImemAddr,
    input  logic                ImemReady,
    input  logic                ImemValid,
    input  logic [31:0]         ImemRdata,
    output logic [31:0]         Instr,
    output logic                InstrValid,
    output logic [31:0]         PC,
    output logic [31:0]         PCPlus4,
    output logic [OP_W-1:0]     Op,
    output logic [FUNCT3_W-1:0] funct3,
    output logic [FUNCT7_W-1:0] funct7,
    output logic                Misaligned,
    output logic [1:0]          state_dbg
);

    // Memory handshake: a request transfers on a cycle with ImemReq=1 and
    // ImemReady=1; its data returns later on any cycle with ImemValid=1 while
    // in WAIT. ImemValid in any other state is ignored.

    fetch_state_t state, state_next;
    logic         kill, kill_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic         advance, capture, misaligned_next;

    pc_next_logic u_pc_next (
        .fetch_pc   (fetch_pc),
        .pc_src     (PCSrc),
        .pc_target  (PCTarget),
        .advance    (advance),
        .next_pc    (fetch_pc_next),
        .misaligned (misaligned_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = REQ;
            REQ:  if (ImemReady) state_next = WAIT;
            WAIT: if (ImemValid) state_next = (kill || PCSrc) ? REQ : HOLD;
            HOLD: if (PCSrc || !Stall) state_next = REQ;
            default: state_next = IDLE;
        endcase
    end

    // kill marks a response that belongs to an address abandoned by redirect.
    always_comb begin
        kill_next = kill;
        case (state)
            REQ:  if (PCSrc && ImemReady) kill_next = 1'b1;
            WAIT: begin
                if (ImemValid) begin
                    kill_next = 1'b0;
                end else if (PCSrc) begin
                    kill_next = 1'b1;
                end
            end
            default: kill_next = 1'b0;
        endcase
    end

    always_comb begin
        ImemReq = (state == REQ);
        capture = (state == WAIT) && ImemValid && !kill && !PCSrc;
        advance = (state == HOLD) && !Stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            kill       <= 1'b0;
            Instr      <= NOP_INSTR;
            InstrValid <= 1'b0;
            PC         <= RESET_PC;
            Misaligned <= 1'b0;
        end else begin
            fetch_pc   <= fetch_pc_next;
            kill       <= kill_next;
            Misaligned <= misaligned_next;
            if (PCSrc) begin
                Instr      <= NOP_INSTR;
                InstrValid <= 1'b0;
            end else if (capture) begin
                Instr      <= ImemRdata;
                PC         <= fetch_pc;
                InstrValid <= 1'b1;
            end else if (advance) begin
                Instr      <= NOP_INSTR;
                InstrValid <= 1'b0;
            end
        end
    end

    assign ImemAddr  = fetch_pc;
    assign PCPlus4   = PC + 32'd4;
    assign Op        = Instr[6:0];
    assign funct3    = Instr[14:12];
    assign funct7    = Instr[31:25];
    assign state_dbg = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed expectations for reset,
// sequential fetch, stall, redirect/kill, misalignment, wrap and mid-transaction reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall, PCSrc, ImemReady, ImemValid;
    logic [31:0] PCTarget, ImemRdata;
    logic        ImemReq, InstrValid, Misaligned;
    logic [31:0] ImemAddr, Instr, PC, PCPlus4;
    logic [6:0]  Op, funct7;
    logic [2:0]  funct3;
    logic [1:0]  state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .Stall      (Stall),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemReady  (ImemReady),
        .ImemValid  (ImemValid),
        .ImemRdata  (ImemRdata),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Misaligned (Misaligned),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, "_instr"}, Instr, NOP);
        check_vec({tag, "_valid"}, 32'(InstrValid), 32'd0);
        check_vec({tag, "_pc"}, PC, 32'h0);
        check_vec({tag, "_req"}, 32'(ImemReq), 32'd0);
        check_vec({tag, "_addr"}, ImemAddr, 32'h0);
        check_vec({tag, "_mis"}, 32'(Misaligned), 32'd0);
        check_vec({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // driver: from REQ with memory ready, one-cycle response of data
    task automatic fetch_word(input logic [31:0] data);
        ImemReady = 1'b1;
        tick();
        ImemValid = 1'b1;
        ImemRdata = data;
        exp_q.push_back(data);
        tick();
        ImemValid = 1'b0;
        ImemRdata = 32'h0;
    endtask

    // scoreboard: held instruction against the oldest expected word
    task automatic check_capture(input string tag, input logic [31:0] exp_pc);
        logic [31:0] exp_w;
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check_vec({tag, "_instr"}, Instr, exp_w);
        check_vec({tag, "_valid"}, 32'(InstrValid), 32'd1);
        check_vec({tag, "_pc"}, PC, exp_pc);
        check_vec({tag, "_pc4"}, PCPlus4, exp_pc + 32'd4);
    endtask

    initial begin
        rst = 1'b1; Stall = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
        ImemReady = 1'b0; ImemValid = 1'b0; ImemRdata = 32'h0;
        tick(); tick();
        check_reset_outputs("rst");

        // first fetch after reset release
        rst = 1'b0;
        ImemReady = 1'b1;
        check_vec("c0_req", 32'(ImemReq), 32'd0);
        tick();
        check_vec("c1_req", 32'(ImemReq), 32'd1);
        check_vec("c1_addr", ImemAddr, 32'h0);
        fetch_word(32'h0050_0093);
        check_capture("f0", 32'h0);
        check_vec("f0_op", 32'(Op), 32'h13);
        check_vec("f0_f3", 32'(funct3), 32'h0);

        // stall holds everything
        Stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec("stall_instr", Instr, 32'h0050_0093);
            check_vec("stall_valid", 32'(InstrValid), 32'd1);
            check_vec("stall_pc", PC, 32'h0);
            check_vec("stall_req", 32'(ImemReq), 32'd0);
        end
        Stall = 1'b0;
        tick();
        check_vec("seq_addr", ImemAddr, 32'h4);
        check_vec("seq_req", 32'(ImemReq), 32'd1);
        check_vec("seq_valid", 32'(InstrValid), 32'd0);
        check_vec("seq_instr", Instr, NOP);

        // redirect while waiting; late response is discarded
        tick();
        check_vec("w_state", 32'(state_dbg), 32'd2);
        PCSrc = 1'b1; PCTarget = 32'h100;
        tick();
        PCSrc = 1'b0;
        check_vec("rw_addr", ImemAddr, 32'h100);
        check_vec("rw_req", 32'(ImemReq), 32'd0);
        tick();
        ImemValid = 1'b1; ImemRdata = 32'hDEAD_BEEF;
        tick();
        ImemValid = 1'b0;
        check_vec("kill_valid", 32'(InstrValid), 32'd0);
        check_vec("kill_instr", Instr, NOP);
        check_vec("kill_req", 32'(ImemReq), 32'd1);
        check_vec("kill_addr", ImemAddr, 32'h100);
        fetch_word(32'h40B5_0533);
        check_capture("f1", 32'h100);
        check_vec("f1_op", 32'(Op), 32'h33);
        check_vec("f1_f7", 32'(funct7), 32'h20);

        // redirect beats stall, misaligned target
        Stall = 1'b1; PCSrc = 1'b1; PCTarget = 32'h203;
        tick();
        PCSrc = 1'b0; Stall = 1'b0; ImemReady = 1'b0;
        check_vec("rs_valid", 32'(InstrValid), 32'd0);
        check_vec("rs_mis", 32'(Misaligned), 32'd1);
        check_vec("rs_addr", ImemAddr, 32'h200);
        check_vec("rs_req", 32'(ImemReq), 32'd1);
        tick();
        check_vec("mis_pulse", 32'(Misaligned), 32'd0);
        check_vec("nr_req", 32'(ImemReq), 32'd1);
        fetch_word(32'h0041_2183);
        check_capture("f2", 32'h200);
        check_vec("f2_op", 32'(Op), 32'h03);
        check_vec("f2_f3", 32'(funct3), 32'h2);

        // address wrap
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
        tick();
        PCSrc = 1'b0;
        check_vec("top_addr", ImemAddr, 32'hFFFF_FFFC);
        check_vec("top_mis", 32'(Misaligned), 32'd0);
        fetch_word(32'h0000_006F);
        check_capture("f3", 32'hFFFF_FFFC);
        tick();
        check_vec("wrap_addr", ImemAddr, 32'h0);

        // redirect in REQ while the old request is accepted
        PCSrc = 1'b1; PCTarget = 32'h40;
        tick();
        PCSrc = 1'b0;
        check_vec("rq_state", 32'(state_dbg), 32'd2);
        ImemValid = 1'b1; ImemRdata = 32'h1234_5678;
        tick();
        ImemValid = 1'b0;
        check_vec("rq_valid", 32'(InstrValid), 32'd0);
        check_vec("rq_instr", Instr, NOP);
        check_vec("rq_addr", ImemAddr, 32'h40);
        check_vec("rq_req", 32'(ImemReq), 32'd1);

        // reset mid-transaction, stray response afterwards
        tick();
        check_vec("pre_rst_state", 32'(state_dbg), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("arst");
        tick();
        rst = 1'b0; ImemReady = 1'b0; ImemValid = 1'b1; ImemRdata = 32'hAAAA_AAAA;
        tick();
        check_vec("stray_valid", 32'(InstrValid), 32'd0);
        check_vec("stray_instr", Instr, NOP);
        tick();
        check_vec("stray2_valid", 32'(InstrValid), 32'd0);
        check_vec("stray2_state", 32'(state_dbg), 32'd1);
        ImemValid = 1'b0;

        check_vec("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
